// File: rtl/morse_tx.sv
// Morse code keyer: accepts one letter/word-space code at a time and drives
// ITU-timed key output from a single down-counting unit timer.
module morse_tx #(
  parameter int UNIT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(7 * UNIT_CYCLES);
  localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T7 = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, ESPACE, LGAP, WGAP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_pat;
  logic [1:0]      r_rem;
  logic            r_key;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [2:0]      w_len;
  logic [3:0]      w_pat;

  // Letter ROM: length 1-4, pattern left-aligned (bit 3 = first element, 1 = dash)
  always_comb begin
    {w_len, w_pat} = 7'd0;
    case (in)
      5'd0:  {w_len, w_pat} = {3'd2, 4'b0100};
      5'd1:  {w_len, w_pat} = {3'd4, 4'b1000};
      5'd2:  {w_len, w_pat} = {3'd4, 4'b1010};
      5'd3:  {w_len, w_pat} = {3'd3, 4'b1000};
      5'd4:  {w_len, w_pat} = {3'd1, 4'b0000};
      5'd5:  {w_len, w_pat} = {3'd4, 4'b0010};
      5'd6:  {w_len, w_pat} = {3'd3, 4'b1100};
      5'd7:  {w_len, w_pat} = {3'd4, 4'b0000};
      5'd8:  {w_len, w_pat} = {3'd2, 4'b0000};
      5'd9:  {w_len, w_pat} = {3'd4, 4'b0111};
      5'd10: {w_len, w_pat} = {3'd3, 4'b1010};
      5'd11: {w_len, w_pat} = {3'd4, 4'b0100};
      5'd12: {w_len, w_pat} = {3'd2, 4'b1100};
      5'd13: {w_len, w_pat} = {3'd2, 4'b1000};
      5'd14: {w_len, w_pat} = {3'd3, 4'b1110};
      5'd15: {w_len, w_pat} = {3'd4, 4'b0110};
      5'd16: {w_len, w_pat} = {3'd4, 4'b1101};
      5'd17: {w_len, w_pat} = {3'd3, 4'b0100};
      5'd18: {w_len, w_pat} = {3'd3, 4'b0000};
      5'd19: {w_len, w_pat} = {3'd1, 4'b1000};
      5'd20: {w_len, w_pat} = {3'd3, 4'b0010};
      5'd21: {w_len, w_pat} = {3'd4, 4'b0001};
      5'd22: {w_len, w_pat} = {3'd3, 4'b0110};
      5'd23: {w_len, w_pat} = {3'd4, 4'b1001};
      5'd24: {w_len, w_pat} = {3'd4, 4'b1011};
      5'd25: {w_len, w_pat} = {3'd4, 4'b1100};
      default: {w_len, w_pat} = 7'd0;
    endcase
  end

  // The counter is reloaded on every transition, so key edges track state edges exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pat   <= 4'd0;
      r_rem   <= 2'd0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in < 5'd26) begin
              r_state <= MARK;
              r_key   <= 1'b1;
              r_busy  <= 1'b1;
              r_pat   <= w_pat;
              r_rem   <= 2'(w_len - 3'd1);
              r_cnt   <= w_pat[3] ? T3 : T1;
            end else if (in == 5'd26) begin
              r_state <= WGAP;
              r_busy  <= 1'b1;
              r_cnt   <= T7;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        MARK: begin
          if (r_cnt == '0) begin
            r_key <= 1'b0;
            if (r_rem == 2'd0) begin
              r_state <= LGAP;
              r_cnt   <= T3;
            end else begin
              r_state <= ESPACE;
              r_cnt   <= T1;
              r_pat   <= {r_pat[2:0], 1'b0};
              r_rem   <= r_rem - 2'd1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ESPACE: begin
          if (r_cnt == '0) begin
            r_state <= MARK;
            r_key   <= 1'b1;
            r_cnt   <= r_pat[3] ? T3 : T1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        LGAP, WGAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_key   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (r_state == IDLE);
  assign key      = r_key;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx with UNIT_CYCLES=4: table of per-symbol
// totals, hand-written corner sequences, and random symbols against a trace model.
module tb_morse_tx;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] in_sym = 5'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, key, busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  logic [4:0] exp_q[$];

  string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  typedef struct {
    logic [4:0] code;
    int         marks;
    int         busy_c;
    int         dones;
    int         errs;
  } vec_t;

  vec_t vecs[7];

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_sym), .in_valid(in_valid),
    .in_ready(in_ready), .key(key), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {key, busy, done, err, in_ready};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_n(input int n, input logic [4:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  // Expected per-cycle {key,busy,done,err,in_ready} after acceptance
  task automatic build(input int code);
    string s;
    if (code < 26) begin
      s = morse[code];
      for (int j = 0; j < s.len(); j++) begin
        push_n((s[j] == "-") ? 3 * U : U, 5'b11000);
        if (j != s.len() - 1) push_n(U, 5'b01000);
      end
      push_n(3 * U, 5'b01000);
      push_n(1, 5'b00101);
    end else if (code == 26) begin
      push_n(7 * U, 5'b01000);
      push_n(1, 5'b00101);
    end else begin
      push_n(1, 5'b00011);
    end
  endtask

  task automatic run_trace(input string nm);
    int k;
    logic [4:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, k), 32'(outs()), 32'(e));
      k++;
    end
  endtask

  task automatic offer(input logic [4:0] c);
    in_sym = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(input vec_t v);
    int marks, bz, dn, er;
    marks = 0; bz = 0; dn = 0; er = 0;
    offer(v.code);
    repeat (64) begin
      @(negedge clk);
      marks += int'(key);
      bz += int'(busy);
      dn += int'(done);
      er += int'(err);
    end
    chk($sformatf("tbl_marks_%0d", v.code), 32'(marks), 32'(v.marks));
    chk($sformatf("tbl_busy_%0d", v.code), 32'(bz), 32'(v.busy_c));
    chk($sformatf("tbl_done_%0d", v.code), 32'(dn), 32'(v.dones));
    chk($sformatf("tbl_err_%0d", v.code), 32'(er), 32'(v.errs));
  endtask

  initial begin
    vecs[0] = '{5'd4,  4,  16, 1, 0};
    vecs[1] = '{5'd0,  16, 32, 1, 0};
    vecs[2] = '{5'd19, 12, 24, 1, 0};
    vecs[3] = '{5'd26, 0,  28, 1, 0};
    vecs[4] = '{5'd30, 0,  0,  0, 1};
    vecs[5] = '{5'd14, 36, 56, 1, 0};
    vecs[6] = '{5'd7,  16, 40, 1, 0};

    #1 rst_n = 1'b0;
    #2 chk("reset_outs", 32'(outs()), 32'(5'b00001));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(outs()), 32'(5'b00001));

    for (int i = 0; i < 7; i++) measure(vecs[i]);

    offer(5'd4);  build(4);  run_trace("e");
    offer(5'd0);  build(0);  run_trace("a");
    offer(5'd26); build(26); run_trace("wspace");
    offer(5'd30); build(30); run_trace("invalid30");

    // 'e' then 't' held on in_valid: 't' must be taken in the done cycle of 'e'
    in_sym = 5'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_sym = 5'd19;
    build(4);
    run_trace("e_b2b");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    build(19);
    run_trace("t_b2b");

    // Reset in the middle of the first dash of 'o'
    offer(5'd14);
    repeat (5) @(negedge clk);
    chk("o_key_before_rst", 32'(key), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(outs()), 32'(5'b00001));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst[%0d]", i), 32'(outs()), 32'(5'b00001));
    end
    offer(5'd8); build(8); run_trace("i_after_rst");

    for (int i = 0; i < 25; i++) begin
      int c;
      c = int'($urandom_range(0, 31));
      offer(5'(c));
      build(c);
      run_trace($sformatf("rand%0d_c%0d", i, c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
